// File: rtl/prbs_randomizer.sv
// Serial PRBS data randomizer, generator 1 + x^14 + x^15.
// One bit per clock when enabled; the seed can be reloaded at any edge.
// data_out is combinational: the bit in the current cycle is scrambled
// with the feedback of the state held during that cycle.
module prbs_randomizer #(
  parameter int unsigned LFSR_LEN = 15,
  parameter int unsigned TAP_A    = 14,
  parameter int unsigned TAP_B    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  input  logic [LFSR_LEN-1:0] seed,
  input  logic                data_in,
  output logic                data_out
);

  // Stage k of the register is r_state[k]; seed bit k-1 lands in stage k.
  logic [LFSR_LEN:1] r_state;
  logic              w_fb;

  assign w_fb = r_state[TAP_A] ^ r_state[TAP_B];

  // LFSR state: async clear, then load over shift over hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= seed;
    end else if (en) begin
      r_state <= {r_state[LFSR_LEN-1:1], w_fb};
    end
  end

  // Scramble the current bit when enabled, otherwise pass it through.
  always_comb begin
    data_out = data_in;
    if (en) begin
      data_out = data_in ^ w_fb;
    end
  end

endmodule

// File: tb/tb_prbs_randomizer.sv
// Self-checking bench for prbs_randomizer: directed vectors with literal
// expectations plus a sequence-level reference model checked every cycle.
module tb_prbs_randomizer;

  localparam int unsigned SEQ_LEN = 33100;

  logic        clk;
  logic        reset;
  logic        load;
  logic        en;
  logic [14:0] seed;
  logic        data_in;
  logic        data_out;

  int checks = 0;
  int errors = 0;

  prbs_randomizer #(
    .LFSR_LEN(15),
    .TAP_A   (14),
    .TAP_B   (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .en      (en),
    .seed    (seed),
    .data_in (data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the generator bit stream g[n] obeys g[n] = g[n-14] ^ g[n-15],
  // with g[-k] = seed stage k. Stored with an offset of 15 so that
  // g_seq[15-k] = stage k and g_seq[15+n] = feedback bit at step n.
  bit          g_seq [0:SEQ_LEN-1];
  int unsigned m_n    = 0;
  bit          m_zero = 1'b1;

  function automatic void model_load(input logic [14:0] s);
    for (int k = 1; k <= 15; k++) g_seq[15-k] = s[k-1];
    for (int j = 15; j < SEQ_LEN; j++) g_seq[j] = g_seq[j-14] ^ g_seq[j-15];
  endfunction

  function automatic bit model_fb();
    if (m_zero) return 1'b0;
    return g_seq[15+m_n];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_zero = 1'b1;
      m_n    = 0;
    end else if (load) begin
      model_load(seed);
      m_zero = 1'b0;
      m_n    = 0;
    end else if (en) begin
      m_n = m_n + 1;
    end
  end

  // Continuous compare against the model, mid-cycle.
  always @(negedge clk) begin
    logic exp_bit;
    exp_bit = en ? (data_in ^ model_fb()) : data_in;
    checks++;
    if (data_out !== exp_bit) begin
      errors++;
      $display("FAIL model_cmp t=%0t n=%0d data_out=%b expected=%b", $time, m_n, data_out, exp_bit);
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Drive one cycle, sample data_out after settling, then cross the edge.
  task automatic cyc(input logic ld, input logic e, input logic d, output logic o);
    load    = ld;
    en      = e;
    data_in = d;
    #2;
    o = data_out;
    @(posedge clk);
    #1;
  endtask

  logic [95:0] vin  = 96'hACBCD2114DAE1577C6DBF4C9;
  logic [95:0] vout = 96'h558AC4A53A1724E163AC2BF9;
  logic [14:0] s_std;
  logic [95:0] cap;
  logic [7:0]  fb8;
  logic [15:0] z_in;
  logic [7:0]  pat;
  logic        o;
  bit          pb [0:32781];
  int          early;
  int          wrap_bad;
  bit          stg [1:15] = '{0,1,1,0,1,1,1,0,0,0,1,0,1,0,1};

  initial begin
    for (int k = 1; k <= 15; k++) s_std[k-1] = stg[k];

    // Reset state: cleared register means pass-through even when enabled.
    reset = 1'b0; load = 1'b0; en = 1'b1; data_in = 1'b1; seed = s_std;
    repeat (2) @(posedge clk);
    #1;
    #1;
    chk("reset_passthru", {95'd0, data_out}, 96'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1. Standard vector.
    seed = s_std;
    cyc(1'b1, 1'b1, 1'b0, o);
    for (int i = 0; i < 8; i++) fb8[7-i] = g_seq[15+i];
    chk("model_fb8", {88'd0, fb8}, {88'd0, 8'b1111_1001});
    cap = '0;
    for (int i = 95; i >= 0; i--) begin
      cyc(1'b0, 1'b1, vin[i], o);
      cap[i] = o;
    end
    chk("std_vector", cap, vout);

    // 2. Enable hold in the middle of the vector.
    cyc(1'b1, 1'b1, 1'b0, o);
    cap = '0;
    for (int i = 95; i >= 86; i--) begin
      cyc(1'b0, 1'b1, vin[i], o);
      cap[i] = o;
    end
    pat = 8'b10110;
    for (int h = 0; h < 5; h++) begin
      cyc(1'b0, 1'b0, pat[h], o);
      chk("hold_passthru", {95'd0, o}, {95'd0, pat[h]});
    end
    for (int i = 85; i >= 0; i--) begin
      cyc(1'b0, 1'b1, vin[i], o);
      cap[i] = o;
    end
    chk("hold_resume", cap, vout);

    // 3. Mid-stream load with en on the same edge restarts the sequence.
    cyc(1'b1, 1'b1, 1'b0, o);
    for (int i = 95; i >= 76; i--) cyc(1'b0, 1'b1, vin[i], o);
    cyc(1'b1, 1'b1, vin[75], o);
    cap = '0;
    for (int i = 95; i >= 80; i--) begin
      cyc(1'b0, 1'b1, vin[i], o);
      cap[i] = o;
      if (i == 95) chk("reload_bit1", {95'd0, o}, 96'd0);
    end
    chk("reload_seq", {80'd0, cap[95:80]}, {80'd0, vout[95:80]});

    // 4. Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, o);
    load = 1'b0; en = 1'b1; data_in = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_out", {95'd0, data_out}, 96'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    pat = 8'hC5;
    cap = '0;
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b1, pat[i], o);
      cap[i] = o;
    end
    chk("post_reset_passthru", cap, {88'd0, 8'hC5});

    // 5. Zero seed gives pass-through.
    seed = 15'd0;
    cyc(1'b1, 1'b1, 1'b0, o);
    z_in = 16'hA5C3;
    cap = '0;
    for (int i = 15; i >= 0; i--) begin
      cyc(1'b0, 1'b1, z_in[i], o);
      cap[i] = o;
    end
    chk("zero_seed", cap, {80'd0, 16'hA5C3});

    // 6. Period of the generator with a non-zero seed.
    seed = s_std;
    cyc(1'b1, 1'b1, 1'b0, o);
    for (int i = 0; i < 32782; i++) begin
      cyc(1'b0, 1'b1, 1'b0, o);
      pb[i] = o;
    end
    wrap_bad = 0;
    for (int j = 0; j < 15; j++) if (pb[j] != pb[j+32767]) wrap_bad++;
    chk("period_wrap", 96'(wrap_bad), 96'd0);
    early = 0;
    for (int p = 1; p < 32767; p++) begin
      bit same;
      same = 1'b1;
      for (int j = 0; j < 15; j++) if (pb[p+j] != pb[j]) same = 1'b0;
      if (same) early++;
    end
    chk("period_not_early", 96'(early), 96'd0);
    chk("period_first8", {88'd0, pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7]},
        {88'd0, 8'b1111_1001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
